// File: rtl/string_led_sequencer.sv
// -----------------------------------------------------------------------------
// string_led_sequencer
//
// Streams the LED byte buffer out of SRAM port 1 onto a single serial line.
// Bytes w_first..w_last are fetched in turn, with wrap-around at 2^ASIZE. The
// whole pass is repeated w_count+1 times. Each byte goes out MSB first. Each
// bit lasts four ticks:
//   - a '1' is high for 3 ticks, then low for 1;
//   - a '0' is high for 1 tick, then low for 3.
// A tick is prescaler+1 clock cycles.
//
// Optional feature, macro STRING_LED_RESET_GAP_EN:
//   After the final byte, the block holds the line low for RESET_TICKS ticks
//   with progress still high, then returns to idle. Without the macro the last
//   byte returns straight to idle.
//
// Ports:
//   clk, rst_n      clock (rising edge); asynchronous active-low reset
//   controller_en   enable; dropping it aborts any sequence on the next edge
//   prescaler       tick period minus one, sampled live
//   polarity        1 inverts the serial line, sampled live
//   w_count         extra passes (passes = w_count+1)
//   w_first/w_last  first/last SRAM byte address, latched at start
//   start           single-cycle start strobe, honoured only in idle
//   progress        high while a sequence is active
//   cs_n, addr      SRAM port-1 chip select (active low) and address
//   rdata           SRAM port-1 read data, valid the cycle after cs_n low
//   dout            serial LED line
// -----------------------------------------------------------------------------
module string_led_sequencer #(
   parameter int ASIZE       = 32,
   parameter int PSIZE       = 32,
   parameter int RESET_TICKS = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             controller_en,
   input  logic [PSIZE-1:0] prescaler,
   input  logic             polarity,
   input  logic [3:0]       w_count,
   input  logic [ASIZE-1:0] w_first,
   input  logic [ASIZE-1:0] w_last,
   input  logic             start,
   output logic             progress,
   output logic             cs_n,
   output logic [ASIZE-1:0] addr,
   input  logic [7:0]       rdata,
   output logic             dout
);

`ifdef STRING_LED_RESET_GAP_EN
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_GAP} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT} state_t;
`endif

   state_t           state_q, state_d;
   logic [ASIZE-1:0] ptr_q, ptr_d;
   logic [ASIZE-1:0] first_q, first_d;
   logic [ASIZE-1:0] last_q, last_d;
   logic [3:0]       count_q, count_d;
   logic [3:0]       pass_q, pass_d;
   logic [7:0]       sreg_q, sreg_d;
   logic [PSIZE-1:0] tick_q, tick_d;
   logic [1:0]       phase_q, phase_d;
   logic [2:0]       bit_q, bit_d;
`ifdef STRING_LED_RESET_GAP_EN
   logic [31:0]      gap_q, gap_d;
`else
   // RESET_TICKS only matters when the gap state is built in.
   logic             unused_reset_ticks;
   assign unused_reset_ticks = (RESET_TICKS != 0);
`endif

   logic tick_fire;
   logic line;

   // ">=" rather than "==" so that lowering prescaler live while the tick
   // counter is above the new value still produces a tick instead of a
   // counter wrap through 2^PSIZE.
   assign tick_fire = (tick_q >= prescaler);

   // MSB of the shift register is the bit in flight. Phase 0 is always high,
   // phase 3 always low, and phases 1-2 follow the bit value.
   assign line = (state_q == S_SHIFT) &&
                 ((phase_q == 2'd0) || (sreg_q[7] && (phase_q != 2'd3)));

   assign dout     = line ^ polarity;
   assign progress = (state_q != S_IDLE);
   assign cs_n     = (state_q != S_FETCH);
   assign addr     = ptr_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      first_d = first_q;
      last_d  = last_q;
      count_d = count_q;
      pass_d  = pass_q;
      sreg_d  = sreg_q;
      tick_d  = tick_q;
      phase_d = phase_q;
      bit_d   = bit_q;
`ifdef STRING_LED_RESET_GAP_EN
      gap_d   = gap_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start && controller_en) begin
               first_d = w_first;
               last_d  = w_last;
               count_d = w_count;
               ptr_d   = w_first;
               pass_d  = 4'd0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            state_d = S_LOAD;
         end

         S_LOAD: begin
            sreg_d  = rdata;
            tick_d  = '0;
            phase_d = 2'd0;
            bit_d   = 3'd0;
            state_d = S_SHIFT;
         end

         S_SHIFT: begin
            if (tick_fire) begin
               tick_d  = '0;
               phase_d = phase_q + 2'd1;
               if (phase_q == 2'd3) begin
                  sreg_d = {sreg_q[6:0], 1'b0};
                  bit_d  = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     // Byte finished: advance within the pass, start the
                     // next pass, or finish.
                     if (ptr_q != last_q) begin
                        ptr_d   = ptr_q + ASIZE'(1);
                        state_d = S_FETCH;
                     end else if (pass_q != count_q) begin
                        pass_d  = pass_q + 4'd1;
                        ptr_d   = first_q;
                        state_d = S_FETCH;
                     end else begin
`ifdef STRING_LED_RESET_GAP_EN
                        gap_d   = 32'd0;
                        state_d = S_GAP;
`else
                        state_d = S_IDLE;
`endif
                     end
                  end
               end
            end else begin
               tick_d = tick_q + PSIZE'(1);
            end
         end

`ifdef STRING_LED_RESET_GAP_EN
         S_GAP: begin
            if (tick_fire) begin
               tick_d = '0;
               if (gap_q >= $unsigned(RESET_TICKS - 1)) begin
                  state_d = S_IDLE;
               end else begin
                  gap_d = gap_q + 32'd1;
               end
            end else begin
               tick_d = tick_q + PSIZE'(1);
            end
         end
`endif

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Disable wins over everything: abort to idle on the next edge.
      if (!controller_en) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         first_q <= '0;
         last_q  <= '0;
         count_q <= 4'd0;
         pass_q  <= 4'd0;
         sreg_q  <= 8'd0;
         tick_q  <= '0;
         phase_q <= 2'd0;
         bit_q   <= 3'd0;
`ifdef STRING_LED_RESET_GAP_EN
         gap_q   <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         first_q <= first_d;
         last_q  <= last_d;
         count_q <= count_d;
         pass_q  <= pass_d;
         sreg_q  <= sreg_d;
         tick_q  <= tick_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
`ifdef STRING_LED_RESET_GAP_EN
         gap_q   <= gap_d;
`endif
      end
   end

endmodule

// File: tb/tb_string_led_sequencer.sv
module tb_string_led_sequencer;

   localparam int RT = 200;
`ifdef STRING_LED_RESET_GAP_EN
   localparam int GAP_T = RT;
`else
   localparam int GAP_T = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        controller_en;
   logic [31:0] prescaler;
   logic        polarity;
   logic [3:0]  w_count;
   logic [31:0] w_first;
   logic [31:0] w_last;
   logic        start;
   logic        progress;
   logic        cs_n;
   logic [31:0] addr;
   logic [7:0]  rdata;
   logic        dout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   string_led_sequencer #(.ASIZE(32), .PSIZE(32), .RESET_TICKS(RT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .controller_en (controller_en),
      .prescaler     (prescaler),
      .polarity      (polarity),
      .w_count       (w_count),
      .w_first       (w_first),
      .w_last        (w_last),
      .start         (start),
      .progress      (progress),
      .cs_n          (cs_n),
      .addr          (addr),
      .rdata         (rdata),
      .dout          (dout)
   );

   // SRAM contents.
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'd5:   return 8'hA5;
         32'd7:   return 8'h00;
         default: return a[7:0] ^ 8'h3C;
      endcase
   endfunction

   // SRAM port 1: registered read, data valid the cycle after cs_n low.
   always @(posedge clk) begin
      if (!cs_n) rdata <= mem_byte(addr);
   end

   typedef struct packed {
      logic        prog;
      logic        cs_n;
      logic        dout;
      logic [31:0] addr;
   } cyc_t;

   cyc_t exp_q[$];

   typedef struct {
      logic [31:0] f;
      logic [31:0] l;
      logic [3:0]  c;
      int          p;
      logic        pol;
      bit          poke;
      int          lat;   // cycles from start edge to first idle cycle, no gap
      int          nf;    // expected number of fetches
      string       name;
   } seq_t;

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   // Reference waveform: one entry per cycle after the start edge.
   task automatic build_model(input seq_t v);
      logic [31:0] ptr;
      logic [7:0]  b;
      int          pass;
      int          bi, ph;
      logic        ln;
      ptr  = v.f;
      pass = 0;
      forever begin
         exp_q.push_back('{1'b1, 1'b0, v.pol, ptr});
         exp_q.push_back('{1'b1, 1'b1, v.pol, 32'd0});
         b = mem_byte(ptr);
         for (int cyc = 0; cyc < 32 * (v.p + 1); cyc++) begin
            bi = cyc / (4 * (v.p + 1));
            ph = (cyc / (v.p + 1)) % 4;
            ln = b[7 - bi] ? (ph < 3) : (ph == 0);
            exp_q.push_back('{1'b1, 1'b1, ln ^ v.pol, 32'd0});
         end
         if (ptr != v.l) ptr = ptr + 32'd1;
         else if (pass != int'(v.c)) begin
            pass++;
            ptr = v.f;
         end else break;
      end
      for (int g = 0; g < GAP_T * (v.p + 1); g++)
         exp_q.push_back('{1'b1, 1'b1, v.pol, 32'd0});
      exp_q.push_back('{1'b0, 1'b1, v.pol, 32'd0});
   endtask

   // Called just after a negedge. Starts a sequence and checks every cycle.
   task automatic run_seq(input seq_t v);
      cyc_t a, e;
      int   lat, nf, exp_lat;
      lat = -1;
      nf  = 0;
      exp_lat = v.lat + GAP_T * (v.p + 1);
      w_first = v.f; w_last = v.l; w_count = v.c;
      prescaler = 32'(v.p); polarity = v.pol;
      controller_en = 1'b1; start = 1'b1;
      build_model(v);
      @(posedge clk);
      for (int k = 1; k <= exp_lat + 64; k++) begin
         @(negedge clk);
         // Scramble config after start: the DUT must use its latched copies.
         start   = v.poke && (k == 5);
         w_first = 32'hDEAD_0010;
         w_last  = 32'hDEAD_0020;
         w_count = ~v.c;
         a = '{progress, cs_n, dout, addr};
         if (!cs_n) nf++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (a.prog !== e.prog || a.cs_n !== e.cs_n || a.dout !== e.dout ||
                (!e.cs_n && a.addr !== e.addr)) begin
               n_errors++;
               $display("FAIL %s cycle %0d: actual prog=%b cs_n=%b dout=%b addr=%h required prog=%b cs_n=%b dout=%b addr=%h",
                        v.name, k, a.prog, a.cs_n, a.dout, a.addr, e.prog, e.cs_n, e.dout, e.addr);
            end
         end
         if (!progress) begin
            lat = k;
            break;
         end
      end
      exp_q.delete();
      chk(lat == exp_lat, {v.name, "_latency"}, 64'(lat), 64'(exp_lat));
      chk(nf == v.nf, {v.name, "_fetches"}, 64'(nf), 64'(v.nf));
   endtask

   seq_t vec[6];
   seq_t s;

   initial begin
      vec[0] = '{f:32'd5,          l:32'd5,  c:4'd0,  p:0, pol:1'b0, poke:1'b0, lat:35,  nf:1,  name:"single_a5"};
      vec[1] = '{f:32'd2,          l:32'd4,  c:4'd1,  p:3, pol:1'b0, poke:1'b0, lat:781, nf:6,  name:"multi_pass"};
      vec[2] = '{f:32'hFFFF_FFFF,  l:32'd1,  c:4'd0,  p:0, pol:1'b0, poke:1'b0, lat:103, nf:3,  name:"wrap"};
      vec[3] = '{f:32'd7,          l:32'd7,  c:4'd0,  p:1, pol:1'b1, poke:1'b1, lat:67,  nf:1,  name:"pol_zero"};
      vec[4] = '{f:32'd10,         l:32'd10, c:4'd15, p:0, pol:1'b0, poke:1'b0, lat:545, nf:16, name:"max_pass"};
      vec[5] = '{f:32'd0,          l:32'd2,  c:4'd2,  p:1, pol:1'b1, poke:1'b1, lat:595, nf:9,  name:"pol_multi"};

      rst_n = 1'b0; controller_en = 1'b0; prescaler = 32'd0; polarity = 1'b0;
      w_count = 4'd0; w_first = 32'd0; w_last = 32'd0; start = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(progress == 1'b0, "rst_progress", 64'(progress), 64'd0);
      chk(cs_n == 1'b1, "rst_cs_n", 64'(cs_n), 64'd1);
      chk(addr == 32'd0, "rst_addr", 64'(addr), 64'd0);
      chk(dout == 1'b0, "rst_dout_pol0", 64'(dout), 64'd0);
      polarity = 1'b1;
      #1;
      chk(dout == 1'b1, "rst_dout_pol1", 64'(dout), 64'd1);
      polarity = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Start while disabled is ignored
      controller_en = 1'b0; start = 1'b1; w_first = 32'd3; w_last = 32'd3;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk(progress == 1'b0 && cs_n == 1'b1, "start_while_disabled",
             64'({progress, cs_n}), 64'({1'b0, 1'b1}));
         @(negedge clk);
      end

      // Table-driven sequences
      for (int i = 0; i < 6; i++) begin
         run_seq(vec[i]);
         @(negedge clk);
      end

      // Abort mid-byte, then restart one cycle later
      w_first = 32'd3; w_last = 32'd3; w_count = 4'd0; prescaler = 32'd0;
      polarity = 1'b0; controller_en = 1'b1; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      chk(progress == 1'b1, "abort_pre_progress", 64'(progress), 64'd1);
      controller_en = 1'b0;
      @(negedge clk);
      chk(progress == 1'b0, "abort_progress", 64'(progress), 64'd0);
      chk(dout == 1'b0, "abort_dout", 64'(dout), 64'd0);
      chk(cs_n == 1'b1, "abort_cs_n", 64'(cs_n), 64'd1);
      s = '{f:32'd8, l:32'd8, c:4'd0, p:0, pol:1'b0, poke:1'b0, lat:35, nf:1, name:"restart"};
      run_seq(s);
      @(negedge clk);

      // Asynchronous reset in the middle of a sequence
      w_first = 32'd2; w_last = 32'd4; w_count = 4'd0; prescaler = 32'd0;
      controller_en = 1'b1; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      chk(progress == 1'b0, "async_rst_progress", 64'(progress), 64'd0);
      chk(cs_n == 1'b1, "async_rst_cs_n", 64'(cs_n), 64'd1);
      chk(addr == 32'd0, "async_rst_addr", 64'(addr), 64'd0);
      chk(dout == 1'b0, "async_rst_dout", 64'(dout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk(progress == 1'b0 && cs_n == 1'b1, "post_rst_idle",
          64'({progress, cs_n}), 64'({1'b0, 1'b1}));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/string_led_sequencer.md
# string_led_sequencer

Sequencer that drives the serial LED string from the byte buffer held in the dual-port SRAM. It sits beside the Wishbone register block and owns the read-only port 1 (`cs1_n`/`addr1`/`rdata1`) of `generic_sram_1rw1r`. It consumes the configuration outputs of the register block (`controller_en`, `polarity`, `w_count`, `w_first`, `w_last`, `start`) and returns `progress`. The register block raises its interrupt on the falling edge of `progress`. The sequencer fetches bytes `w_first..w_last`, repeats the pass `w_count+1` times, and serializes each byte MSB-first as pulse-width-coded bits on one output pin.

## Interface
Parameters:
- `ASIZE`, 32, width of the SRAM byte address and of `w_first`/`w_last`.
- `PSIZE`, 32, width of the prescaler value and the tick counter.
- `RESET_TICKS`, 200, ticks of idle line after the final pass; used only with `STRING_LED_RESET_GAP_EN`.

Ports:
- `clk`  in  1  clock, rising edge; the block's only clock.
- `rst_n`  in  1  reset, asynchronous assertion, active low.
- `controller_en`  in  1  enable; low aborts any activity.
- `prescaler`  in  PSIZE  tick period is `prescaler+1` clk cycles.
- `polarity`  in  1  output inversion (1: inverted line).
- `w_count`  in  4  number of extra passes (passes = `w_count+1`, range 1..16).
- `w_first`  in  ASIZE  first byte address.
- `w_last`  in  ASIZE  last byte address.
- `start`  in  1  single-cycle start strobe.
- `progress`  out  1  high while a sequence is active.
- `cs_n`  out  1  SRAM port-1 chip select, active low.
- `addr`  out  ASIZE  SRAM port-1 address.
- `rdata`  in  8  SRAM port-1 read data, valid the cycle after `cs_n` is low.
- `dout`  out  1  serial LED line, equal to `line ^ polarity`.

## Operation
- States: IDLE, FETCH, LOAD, SHIFT, plus GAP when the macro is compiled in.
- IDLE: `cs_n`=1 and `line`=0. On `start && controller_en`:
  - latch `w_first`, `w_last`, `w_count` into internal copies;
  - set `ptr`=`w_first` and `pass`=0;
  - move to FETCH.
- `start` is ignored outside IDLE and while `controller_en`=0.
- FETCH (1 cycle): `cs_n`=0, `addr`=`ptr`. Move to LOAD.
- LOAD (1 cycle): `cs_n`=1. Capture `rdata` into an 8-bit shift register. Clear the tick counter and the bit/phase counters. Move to SHIFT.
- SHIFT: tick counter counts 0..`prescaler` and a tick fires when it reaches `prescaler`. Each bit lasts 4 ticks:
  - bit 1: `line` high for phases 0–2, low for phase 3;
  - bit 0: `line` high for phase 0, low for phases 1–3;
  - bits are sent MSB first.
- After bit 0 of the byte completes:
  - if `ptr`≠`w_last`: `ptr`=`ptr+1` modulo 2^ASIZE, then FETCH;
  - else if `pass`≠latched `w_count`: `pass`+1, `ptr`=latched `w_first`, then FETCH;
  - else: GAP if the macro is compiled in, otherwise IDLE.
- Wrap-around: `w_first` > `w_last` walks upward through 2^ASIZE−1, wraps to 0, and continues up to `w_last`. `w_first`==`w_last` sends one byte per pass.
- Abort: `controller_en`=0 in any non-IDLE state forces IDLE on the next edge. `line`=0, `cs_n`=1 and `progress`=0 from that edge onward.
- `progress`=1 in every state except IDLE.
- `prescaler` and `polarity` are sampled live. Changing them mid-sequence is allowed but distorts the timing of the bit in flight.

## Timing
- Reset values: `progress`=0, `cs_n`=1, `addr`=0, `line`=0, so `dout`=`polarity`. All counters are 0 and the state is IDLE.
- Start latency: `start` sampled at edge N gives FETCH (`cs_n`=0, `addr`=`w_first`) in cycle N+1, LOAD in N+2, and SHIFT with `line`=1 from N+3. `progress` rises in N+1.
- Bit time is 4·(`prescaler`+1) cycles; byte time in SHIFT is 32·(`prescaler`+1) cycles.
- Inter-byte gap is exactly 2 cycles (FETCH+LOAD) with `line`=0.
- End of sequence: `progress` falls on the edge following the last phase of the last bit, or after the GAP phase when the macro is compiled in.
- `rst_n` asserted at any time puts all outputs at their reset values immediately; no partial byte is resumed.

## Configuration
- `STRING_LED_RESET_GAP_EN` defined: after the final byte the block enters GAP, holding `line`=0 for `RESET_TICKS` ticks with `progress`=1, then goes to IDLE. This guarantees the latch/reset low time of the LED protocol before the interrupt fires.
- Not defined: there is no GAP state, the final byte goes straight to IDLE, and software must time the reset gap itself.

## Test plan
- `prescaler`=0, `polarity`=0, `w_first`=`w_last`=5, `w_count`=0, mem[5]=0xA5, `start` → `cs_n` low one cycle with `addr`=5. `dout` shows the pattern 1110,1000,1110,1000,1000,1110,1000,1110 (one cycle per phase). `progress` falls 35 cycles after `start` (without the macro).
- `w_first`=2, `w_last`=4, `w_count`=1, `prescaler`=3 → address sequence 2,3,4,2,3,4. Each byte occupies 128 SHIFT cycles with 2-cycle low gaps between bytes.
- `w_first`=2^ASIZE−1, `w_last`=1 → addresses 0xFFFFFFFF, 0, 1, then done.
- `controller_en` dropped mid-byte → next edge gives `progress`=0 and `dout`=`polarity`. A `start` 1 cycle later begins cleanly at `w_first`.
- `polarity`=1, byte 0x00 → `dout` idles at 1 and is the inverse of the 1000 pattern per bit. `start` pulses while `progress`=1 are ignored.
- With `STRING_LED_RESET_GAP_EN`, `RESET_TICKS`=200, `prescaler`=0 → `progress` stays high for 200 extra cycles with `dout`=0 after the last bit.
